// File: rtl/matrix_output_encoder.sv
// Streams a row-major matrix from synchronous-read storage to a UART as signed
// decimal ASCII text, separating elements with spaces and ending each row with a newline.
module matrix_output_encoder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned MAX_DIM = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        rows,
    input  logic [2:0]        cols,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              dim_err
);

    // Wide enough to hold 10^9 even for narrow elements.
    localparam int unsigned MAG_W     = (DATA_W > 30) ? DATA_W : 30;
    localparam logic [2:0]  MAX_DIM_L = 3'(MAX_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SIGN,
        S_DIGIT,
        S_SEP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          rows_q, rows_d;
    logic [2:0]          cols_q, cols_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   mag_q, mag_d;
    logic [3:0]          pow_q, pow_d;
    logic [3:0]          digit_q, digit_d;
    logic                lead_q, lead_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dim_err_q, dim_err_d;

    logic [MAG_W-1:0]    pow_val;
    logic [MAG_W-1:0]    mag_ext;
    logic [MAG_W-1:0]    mag_diff;
    logic                mag_ge;
    logic                last_col;
    logic                last_row;
    logic                tx_fire;

    function automatic logic [MAG_W-1:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = MAG_W'(1);
            4'd1:    pow10 = MAG_W'(10);
            4'd2:    pow10 = MAG_W'(100);
            4'd3:    pow10 = MAG_W'(1000);
            4'd4:    pow10 = MAG_W'(10000);
            4'd5:    pow10 = MAG_W'(100000);
            4'd6:    pow10 = MAG_W'(1000000);
            4'd7:    pow10 = MAG_W'(10000000);
            4'd8:    pow10 = MAG_W'(100000000);
            4'd9:    pow10 = MAG_W'(1000000000);
            default: pow10 = MAG_W'(1);
        endcase
    endfunction

    assign pow_val  = pow10(pow_q);
    assign mag_ext  = MAG_W'(mag_q);
    assign mag_ge   = (mag_ext >= pow_val);
    assign mag_diff = mag_ext - pow_val;
    assign last_col = (col_q == (cols_q - 3'd1));
    assign last_row = (row_q == (rows_q - 3'd1));
    assign tx_fire  = tx_valid_q && tx_ready;

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        row_d      = row_q;
        col_d      = col_q;
        rd_addr_d  = rd_addr_q;
        mag_d      = mag_q;
        pow_d      = pow_q;
        digit_d    = digit_q;
        lead_d     = lead_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dim_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_valid_d = 1'b0;
                if (start) begin
                    if (rows == 3'd0 || cols == 3'd0 || rows > MAX_DIM_L || cols > MAX_DIM_L) begin
                        dim_err_d = 1'b1;
                    end else begin
                        rows_d    = rows;
                        cols_d    = cols;
                        row_d     = 3'd0;
                        col_d     = 3'd0;
                        rd_addr_d = base_addr;
                        busy_d    = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                pow_d   = 4'd9;
                digit_d = 4'd0;
                lead_d  = 1'b0;
                if (rd_data[DATA_W-1]) begin
                    mag_d      = DATA_W'(0) - rd_data;
                    tx_data_d  = 8'h2D;
                    tx_valid_d = 1'b1;
                    state_d    = S_SIGN;
                end else begin
                    mag_d   = rd_data;
                    state_d = S_DIGIT;
                end
            end
            S_SIGN: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        if (pow_q == 4'd0) begin
                            tx_data_d = last_col ? 8'h0A : 8'h20;
                            state_d   = S_SEP;
                        end else begin
                            tx_valid_d = 1'b0;
                            pow_d      = pow_q - 4'd1;
                            digit_d    = 4'd0;
                        end
                    end
                end else if (mag_ge) begin
                    mag_d   = DATA_W'(mag_diff);
                    digit_d = digit_q + 4'd1;
                end else if (digit_q != 4'd0 || lead_q || pow_q == 4'd0) begin
                    tx_data_d  = 8'h30 + 8'(digit_q);
                    tx_valid_d = 1'b1;
                    lead_d     = 1'b1;
                end else begin
                    // Suppressed leading zero: move on without emitting.
                    pow_d   = pow_q - 4'd1;
                    digit_d = 4'd0;
                end
            end
            S_SEP: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    if (last_col && last_row) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = S_FETCH;
                        if (last_col) begin
                            col_d = 3'd0;
                            row_d = row_q + 3'd1;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            rd_addr_q  <= '0;
            mag_q      <= '0;
            pow_q      <= '0;
            digit_q    <= '0;
            lead_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dim_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rd_addr_q  <= rd_addr_d;
            mag_q      <= mag_d;
            pow_q      <= pow_d;
            digit_q    <= digit_d;
            lead_q     <= lead_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dim_err_q  <= dim_err_d;
        end
    end

    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dim_err  = dim_err_q;

endmodule

// File: tb/tb_matrix_output_encoder.sv
// Self-checking bench: printed text is compared against a string-formatting reference
// of the stored matrix, plus handshake, dimension-error and reset behaviour checks.
module tb_matrix_output_encoder;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        rows;
    logic [2:0]        cols;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic              dim_err;

    logic [DATA_W-1:0] mem [DEPTH];

    int          checks = 0;
    int          errors = 0;
    byte         cap[$];
    int          done_cnt = 0;
    int          dim_cnt = 0;
    bit          txv_seen = 1'b0;
    bit          busy_seen = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    matrix_output_encoder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .MAX_DIM(5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rows     (rows),
        .cols     (cols),
        .base_addr(base_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .dim_err  (dim_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read storage: data appears one cycle after the address.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string esc(input string s);
        string r;
        r = s;
        for (int i = 0; i < r.len(); i++)
            if (r.getc(i) == 8'h0A) r.putc(i, 8'h7C);
        return r;
    endfunction

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, esc(obs), esc(exp));
        end
    endtask

    // Reference: signed decimal text of each stored element, space/newline separated.
    function automatic string expect_str(input int r, input int c, input int b);
        string s;
        s = "";
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                int a;
                a = (b + i * c + j) % DEPTH;
                s = {s, $sformatf("%0d", $signed(mem[a]))};
                s = {s, (j == c - 1) ? "\n" : " "};
            end
        end
        return s;
    endfunction

    function automatic string cap_str();
        string s;
        s = "";
        foreach (cap[i]) s = {s, $sformatf("%c", cap[i])};
        return s;
    endfunction

    // Handshake monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", 64'(tx_valid), 64'd1);
            chk("stall_data", 64'(tx_data), 64'(prev_data));
        end
        prev_stall = rst_n && tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (rst_n && tx_valid && tx_ready) cap.push_back(tx_data);
        if (done) done_cnt++;
        if (dim_err) dim_cnt++;
        if (tx_valid) txv_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_dim_err"}, 64'(dim_err), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    endtask

    // mode: 0 ready always high, 1 toggling, 2 random. restart_at: cycle of an extra start (-1 none).
    task automatic run_matrix(input string tag, input int r, input int c, input int b,
                              input int mode, input int restart_at);
        string exp;
        int    cyc;
        exp = expect_str(r, c, b);
        cap.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; rows = 3'(r); cols = 3'(c); base_addr = ADDR_W'(b);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (cyc == restart_at) begin
                start = 1'b1; rows = 3'd2; cols = 3'd2; base_addr = ADDR_W'(40);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        chk({tag, "_timeout"}, 64'(cyc < 20000), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk_str({tag, "_text"}, cap_str(), exp);
    endtask

    task automatic dim_case(input string tag, input int r, input int c);
        dim_cnt = 0; txv_seen = 1'b0; busy_seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; rows = 3'(r); cols = 3'(c); base_addr = ADDR_W'(0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(dim_err), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(dim_cnt), 64'd1);
        chk({tag, "_no_tx"}, 64'(txv_seen), 64'd0);
        chk({tag, "_no_busy"}, 64'(busy_seen), 64'd0);
    endtask

    initial begin
        int cyc;
        int n;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        rst_n = 1'b0; start = 1'b0; rows = 3'd0; cols = 3'd0;
        base_addr = '0; tx_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // 2x2 mixed-sign matrix
        mem[0] = 32'd1; mem[1] = 32'hFFFF_FFEC; mem[2] = 32'd0; mem[3] = 32'd305;
        chk_str("model_2x2", expect_str(2, 2, 0), "1 -20\n0 305\n");
        run_matrix("m2x2", 2, 2, 0, 0, -1);

        // Extremes of the signed range
        mem[8] = 32'h8000_0000;
        run_matrix("min_int", 1, 1, 8, 0, -1);
        chk_str("min_int_lit", cap_str(), "-2147483648\n");
        mem[8] = 32'h7FFF_FFFF;
        run_matrix("max_int", 1, 1, 8, 0, -1);
        chk_str("max_int_lit", cap_str(), "2147483647\n");

        // Illegal dimensions
        dim_case("dim_r0", 0, 3);
        dim_case("dim_r6", 6, 2);
        dim_case("dim_c7", 2, 7);

        // Back-pressure with a second start mid-transfer
        mem[20] = 32'd7; mem[21] = 32'd8; mem[22] = 32'd9;
        run_matrix("stall_1x3", 1, 3, 20, 1, 15);
        chk_str("stall_1x3_lit", cap_str(), "7 8 9\n");

        // Reset during the second row of a 3x3 print
        for (int i = 0; i < 9; i++) mem[30 + i] = 32'(11 + i);
        cap.delete();
        @(posedge clk); #1;
        start = 1'b1; rows = 3'd3; cols = 3'd3; base_addr = ADDR_W'(30);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cap.size() < 11 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_mid_reach", 64'(cyc < 5000), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_outputs("rst_mid");
        n = cap.size();
        txv_seen = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_mid_no_bytes", 64'(cap.size()), 64'(n));
        chk("rst_mid_no_valid", 64'(txv_seen), 64'd0);
        run_matrix("after_rst", 3, 3, 30, 0, -1);

        // Randomized matrices, dims, bases (with address wrap) and back-pressure
        for (int k = 0; k < 6; k++) begin
            int r;
            int c;
            int b;
            r = $urandom_range(1, 5);
            c = $urandom_range(1, 5);
            b = $urandom_range(0, DEPTH - 1);
            for (int i = 0; i < r * c; i++) begin
                case ($urandom_range(0, 3))
                    0:       mem[(b + i) % DEPTH] = $urandom;
                    1:       mem[(b + i) % DEPTH] = '0;
                    2:       mem[(b + i) % DEPTH] = 32'($urandom_range(0, 999));
                    default: mem[(b + i) % DEPTH] = 32'(0) - 32'($urandom_range(1, 999));
                endcase
            end
            run_matrix($sformatf("rand%0d", k), r, c, b, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
